// File: rtl/entropy_conditioner.sv
// Entropy conditioner: pops health-checked noise words from the health FIFO,
// XOR-folds RATIO words into one OUT_W-bit word, drops DISCARD warm-up words
// and presents the result on a valid/ready port. A permanent health failure
// latches a sticky fault and stops all FIFO reads until reset.
module entropy_conditioner #(
    parameter int unsigned SAMPLE_SIZE = 256,
    parameter int unsigned OUT_W       = 32,
    parameter int unsigned RATIO       = 2,
    parameter int unsigned DISCARD     = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SAMPLE_SIZE-1:0] fifo_rdata,
    input  logic                   fifo_empty,
    output logic                   fifo_deque,
    input  logic                   inter_fail,
    input  logic                   perm_fail,
    output logic [OUT_W-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   fault,
    output logic [15:0]            words_out
);

    localparam int unsigned NCHUNK = SAMPLE_SIZE / OUT_W;
    localparam int unsigned CIDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned SCNT_W = $clog2(RATIO + 1);
    localparam int unsigned DCNT_W = (DISCARD > 0) ? $clog2(DISCARD + 1) : 1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] POP   = 3'd1;
    localparam logic [2:0] LATCH = 3'd2;
    localparam logic [2:0] FOLD  = 3'd3;
    localparam logic [2:0] OUT   = 3'd4;
    localparam logic [2:0] FAULT = 3'd5;

    logic [2:0]                   state, state_d;
    logic [OUT_W-1:0]             acc, acc_d;
    logic [CIDX_W-1:0]            chunk_idx, chunk_idx_d;
    logic [SCNT_W-1:0]            sample_cnt, sample_cnt_d;
    logic [DCNT_W-1:0]            discard_cnt, discard_cnt_d;
    logic [NCHUNK-1:0][OUT_W-1:0] sample_reg, sample_reg_d;
    logic [OUT_W-1:0]             out_data_d;
    logic                         out_valid_d;
    logic                         fault_d;
    logic [15:0]                  words_out_d;

    logic [OUT_W-1:0]             acc_x;
    logic [SCNT_W-1:0]            sample_cnt_inc;

    // Pop strobe is a pure decode of the POP state
    assign fifo_deque = (state == POP);

    // Next-state and datapath update
    always_comb begin
        state_d       = state;
        acc_d         = acc;
        chunk_idx_d   = chunk_idx;
        sample_cnt_d  = sample_cnt;
        discard_cnt_d = discard_cnt;
        sample_reg_d  = sample_reg;
        out_data_d    = out_data;
        out_valid_d   = out_valid;
        fault_d       = fault;
        words_out_d   = words_out;

        acc_x          = acc ^ sample_reg[chunk_idx];
        sample_cnt_inc = sample_cnt + SCNT_W'(1);

        case (state)
            IDLE, POP, LATCH, FOLD: begin
                if (inter_fail) begin
                    // Abort the word in progress and restart warm-up
                    acc_d         = '0;
                    sample_cnt_d  = '0;
                    chunk_idx_d   = '0;
                    discard_cnt_d = '0;
                    state_d       = IDLE;
                end else begin
                    case (state)
                        IDLE: begin
                            if (!fifo_empty) state_d = POP;
                        end
                        POP: begin
                            state_d = LATCH;
                        end
                        LATCH: begin
                            sample_reg_d = fifo_rdata;
                            chunk_idx_d  = '0;
                            state_d      = FOLD;
                        end
                        default: begin
                            acc_d       = acc_x;
                            chunk_idx_d = chunk_idx + CIDX_W'(1);
                            if (chunk_idx == CIDX_W'(NCHUNK - 1)) begin
                                chunk_idx_d = '0;
                                if (32'(sample_cnt_inc) < RATIO) begin
                                    sample_cnt_d = sample_cnt_inc;
                                    state_d      = IDLE;
                                end else if (32'(discard_cnt) < DISCARD) begin
                                    discard_cnt_d = discard_cnt + DCNT_W'(1);
                                    acc_d         = '0;
                                    sample_cnt_d  = '0;
                                    state_d       = IDLE;
                                end else begin
                                    out_data_d   = acc_x;
                                    out_valid_d  = 1'b1;
                                    acc_d        = '0;
                                    sample_cnt_d = '0;
                                    state_d      = OUT;
                                end
                            end
                        end
                    endcase
                end
            end
            OUT: begin
                // A completed word survives an intermittent failure
                if (inter_fail) begin
                    discard_cnt_d = '0;
                    acc_d         = '0;
                end
                if (out_valid && out_ready) begin
                    out_valid_d = 1'b0;
                    words_out_d = words_out + 16'd1;
                    state_d     = IDLE;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Permanent failure overrides everything except reset
        if (perm_fail) begin
            state_d     = FAULT;
            fault_d     = 1'b1;
            out_valid_d = 1'b0;
            words_out_d = words_out;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            chunk_idx   <= '0;
            sample_cnt  <= '0;
            discard_cnt <= '0;
            sample_reg  <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            fault       <= 1'b0;
            words_out   <= '0;
        end else begin
            state       <= state_d;
            acc         <= acc_d;
            chunk_idx   <= chunk_idx_d;
            sample_cnt  <= sample_cnt_d;
            discard_cnt <= discard_cnt_d;
            sample_reg  <= sample_reg_d;
            out_data    <= out_data_d;
            out_valid   <= out_valid_d;
            fault       <= fault_d;
            words_out   <= words_out_d;
        end
    end

endmodule
